// File: rtl/uart_rx_pkg.sv
// UART receiver shared definitions.
// States, widths and legal oversampling ratios.
package uart_rx_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int PRESC_W_DEF = 6;
  localparam int BIT_CNT_W = 4;

  localparam int unsigned PRESC_8 = 8;
  localparam int unsigned PRESC_16 = 16;
  localparam int unsigned PRESC_32 = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  function automatic logic presc_legal(
    input int unsigned p
  );
    return (p == PRESC_8) ||
           (p == PRESC_16) ||
           (p == PRESC_32);
  endfunction

endpackage

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// Oversample edge counter and bit counter.
// Both clear whenever enable is low.
module edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF,
  parameter int BIT_W = BIT_CNT_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               enable,
  input  logic [PRESC_W-1:0] prescale,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               bit_end
);

  logic [PRESC_W-1:0] last_edge;

  assign last_edge = prescale - PRESC_W'(1);
  // >= keeps the count bounded even for odd ratios
  assign bit_end = (edge_cnt >= last_edge);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (bit_end) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + BIT_W'(1);
    end else begin
      edge_cnt <= edge_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller.
// Sequences start/data/parity/stop and flags good bytes.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               samp_valid,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic               dat_samp_en,
  output logic               strt_chk_en,
  output logic               deser_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               data_valid
);

  rx_state_t            state;
  logic [PRESC_W-1:0]   presc_q;
  logic                 par_en_q;
  logic                 par_bad;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 bit_end;
  logic                 cnt_en;
  logic                 go;

  // An illegal ratio keeps the receiver parked in IDLE
  assign go = !RX_IN &&
              presc_legal(32'(Prescale));

  // Drop enable on the final stop edge so a
  // back-to-back frame starts from bit 0
  assign cnt_en = (state != IDLE) &&
                  !((state == STOP) && bit_end);

  edge_bit_counter #(
    .PRESC_W (PRESC_W),
    .BIT_W   (BIT_CNT_W)
  ) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .enable   (cnt_en),
    .prescale (presc_q),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_end  (bit_end)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      par_bad    <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            state    <= START;
            presc_q  <= Prescale;
            par_en_q <= PAR_EN;
            par_bad  <= 1'b0;
          end
        end
        START: begin
          if (bit_end)
            state <= strt_glitch ? IDLE : DATA;
        end
        DATA: begin
          if (bit_end &&
              bit_cnt == BIT_CNT_W'(DATA_WIDTH))
            state <= par_en_q ? PARITY : STOP;
        end
        PARITY: begin
          if (samp_valid || bit_end)
            par_bad <= par_err;
          if (bit_end)
            state <= STOP;
        end
        STOP: begin
          if (bit_end) begin
            data_valid <= !stp_err && !par_bad;
            if (go) begin
              state    <= START;
              presc_q  <= Prescale;
              par_en_q <= PAR_EN;
              par_bad  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dat_samp_en = 1'b0;
    strt_chk_en = 1'b0;
    deser_en    = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    unique case (1'b1)
      (state == START): begin
        dat_samp_en = 1'b1;
        strt_chk_en = 1'b1;
      end
      (state == DATA): begin
        dat_samp_en = 1'b1;
        deser_en    = 1'b1;
      end
      (state == PARITY): begin
        dat_samp_en = 1'b1;
        par_chk_en  = 1'b1;
      end
      (state == STOP): begin
        dat_samp_en = 1'b1;
        stp_chk_en  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm.
// Includes a small behavioural sampler/checker datapath.
module tb_uart_rx_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       samp_valid = 1'b0;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic [5:0] edge_cnt;
  logic       dat_samp_en;
  logic       strt_chk_en;
  logic       deser_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       data_valid;

  int passes = 0;
  int total = 0;
  int cur_p = 8;
  int vcnt, par_cyc, stp_cyc;
  int deser_cyc, strt_cyc;
  logic [5:0] emax;
  logic [7:0] shreg = 8'h00;
  logic [7:0] got;
  logic s;
  time vt[2];
  time t_start;
  longint lat;

  uart_rx_fsm dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .Prescale    (Prescale),
    .samp_valid  (samp_valid),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .dat_samp_en (dat_samp_en),
    .strt_chk_en (strt_chk_en),
    .deser_en    (deser_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid)
  );

  always #5 CLK = ~CLK;

  // Mid-bit sampler, checkers, deserializer and monitor
  always @(negedge CLK) begin
    samp_valid = 1'b0;
    if (dat_samp_en &&
        int'(edge_cnt) == cur_p / 2) begin
      s = RX_IN;
      samp_valid = 1'b1;
      if (strt_chk_en) strt_glitch = s;
      if (deser_en) shreg = {s, shreg[7:1]};
      if (par_chk_en) par_err = s ^ (^shreg);
      if (stp_chk_en) stp_err = !s;
    end
    if (data_valid) begin
      if (vcnt < 2) vt[vcnt] = $time;
      got = shreg;
      vcnt++;
    end
    if (par_chk_en) par_cyc++;
    if (stp_chk_en) stp_cyc++;
    if (deser_en) deser_cyc++;
    if (strt_chk_en) strt_cyc++;
    if (edge_cnt > emax) emax = edge_cnt;
  end

  function automatic logic [31:0] outs();
    return 32'({edge_cnt, dat_samp_en,
                strt_chk_en, deser_en,
                par_chk_en, stp_chk_en,
                data_valid});
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic clr();
    vcnt = 0;
    par_cyc = 0;
    stp_cyc = 0;
    deser_cyc = 0;
    strt_cyc = 0;
    emax = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_frame(
    input logic [7:0] d,
    input int         p,
    input logic       pe,
    input logic       flip,
    input logic       stop_bit,
    input int         abort_bit
  );
    logic [11:0] bits;
    int nb;
    Prescale = 6'(p);
    PAR_EN = pe;
    cur_p = p;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (pe) begin
      bits[9] = (^d) ^ flip;
      bits[10] = stop_bit;
      nb = 11;
    end else begin
      bits[9] = stop_bit;
      nb = 10;
    end
    t_start = $time;
    for (int i = 0; i < nb; i++) begin
      RX_IN = bits[i];
      if (i == abort_bit) begin
        repeat (p / 2) @(negedge CLK);
        return;
      end
      repeat (p) @(negedge CLK);
    end
    RX_IN = 1'b1;
  endtask

  initial begin
    clr();
    #2 RST = 1'b0;
    idle(3);
    chk("reset_outs", outs(), 32'h0);
    RST = 1'b1;
    idle(3);

    clr();
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1);
    idle(20);
    chk("a5_valid_cnt", 32'(vcnt), 1);
    lat = longint'((vt[0] - t_start - 10) / 10);
    chk("a5_latency", 32'(lat), 80);
    chk("a5_byte", 32'(got), 32'hA5);
    chk("a5_idle_outs", outs(), 32'h0);
    chk("a5_edge_max", 32'(emax), 7);
    chk("a5_no_parity", 32'(par_cyc), 0);

    clr();
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, -1);
    idle(20);
    chk("3c_par_cycles", 32'(par_cyc), 16);
    chk("3c_valid_cnt", 32'(vcnt), 1);
    chk("3c_byte", 32'(got), 32'h3C);

    clr();
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, -1);
    idle(20);
    chk("parerr_valid_cnt", 32'(vcnt), 0);
    chk("parerr_stop_cyc", 32'(stp_cyc), 16);
    clr();
    send_frame(8'h81, 16, 1'b1, 1'b0, 1'b1, -1);
    idle(20);
    chk("after_parerr_valid", 32'(vcnt), 1);
    chk("after_parerr_byte", 32'(got), 32'h81);

    clr();
    Prescale = 6'd8;
    PAR_EN = 1'b0;
    cur_p = 8;
    RX_IN = 1'b0;
    idle(3);
    RX_IN = 1'b1;
    idle(20);
    chk("glitch_start_cyc", 32'(strt_cyc), 8);
    chk("glitch_no_deser", 32'(deser_cyc), 0);
    chk("glitch_no_valid", 32'(vcnt), 0);
    chk("glitch_idle", 32'(dat_samp_en), 0);

    clr();
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, -1);
    idle(30);
    chk("stperr_valid_cnt", 32'(vcnt), 0);
    chk("stperr_stop_cyc", 32'(stp_cyc), 8);

    clr();
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, -1);
    idle(20);
    chk("b2b_valid_cnt", 32'(vcnt), 2);
    lat = longint'((vt[1] - vt[0]) / 10);
    chk("b2b_gap", 32'(lat), 80);
    chk("b2b_byte", 32'(got), 32'h55);

    clr();
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 5);
    chk("rst_in_data", 32'(deser_en), 1);
    RX_IN = 1'b1;
    RST = 1'b0;
    #1;
    chk("rst_mid_outs", outs(), 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    idle(5);
    clr();
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, -1);
    idle(20);
    chk("post_rst_valid", 32'(vcnt), 1);
    chk("post_rst_byte", 32'(got), 32'h96);
    lat = longint'((vt[0] - t_start - 10) / 10);
    chk("post_rst_latency", 32'(lat), 80);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
